// File: rtl/dmem_port.sv
// Data-memory port for the pipelined core: valid/ready request channel, fixed access
// latency, lane-masked stores, extended loads, error flagging and saturating statistics.
module dmem_port #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned STAT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [STAT_WIDTH-1:0] stat_loads_o,
    output logic [STAT_WIDTH-1:0] stat_stores_o,
    output logic [STAT_WIDTH-1:0] stat_errs_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS * 4);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] AddrLimit = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0] CntInit = 3'(LATENCY - 1);
    localparam logic [STAT_WIDTH-1:0] StatMax = '1;
    localparam logic [STAT_WIDTH-1:0] StatOne = {{(STAT_WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic [STAT_WIDTH-1:0] stat_loads_q, stat_stores_q, stat_errs_q;

    logic accept;
    assign accept = req_valid_i && req_ready_o;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? StResp : StWait;
                    cnt_d   = CntInit;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            StIdle:  req_ready_o = rst_ni;
            StResp: begin
                req_ready_o = rst_ni;
                rsp_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                write_q    <= req_write_i;
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                addr_q     <= req_addr_i;
                wdata_q    <= req_wdata_i;
            end
        end
    end

    // The edge entering RESP comes from WAIT (captured request) or straight from an
    // accept when LATENCY is 1 (live request).
    logic        use_q, enter_resp;
    logic        acc_write, acc_unsigned;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata;

    assign use_q        = (state_q == StWait);
    assign enter_resp   = (state_d == StResp);
    assign acc_write    = use_q ? write_q    : req_write_i;
    assign acc_size     = use_q ? size_q     : req_size_i;
    assign acc_unsigned = use_q ? unsigned_q : req_unsigned_i;
    assign acc_addr     = use_q ? addr_q     : req_addr_i;
    assign acc_wdata    = use_q ? wdata_q    : req_wdata_i;

    logic          misaligned, out_of_range, acc_err;
    logic [IW-1:0] idx;

    assign misaligned   = (acc_size == 2'b11) ||
                          (acc_size == 2'b01 && acc_addr[0]) ||
                          (acc_size == 2'b10 && acc_addr[1:0] != 2'b00);
    assign out_of_range = (acc_addr >= AddrLimit);
    assign acc_err      = misaligned || out_of_range;
    assign idx          = acc_addr[AW-1:2];

    // ---------------- lane steering ----------------
    logic [3:0]  be;
    logic [31:0] wr_word, rd_word, rd_shift, load_data;

    assign rd_word  = mem_q[idx];
    assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};

    always_comb begin
        be        = 4'b0000;
        wr_word   = acc_wdata;
        load_data = rd_word;
        unique case (acc_size)
            2'b00: begin
                be        = 4'b0001 << acc_addr[1:0];
                wr_word   = {4{acc_wdata[7:0]}};
                load_data = {{24{~acc_unsigned & rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b01: begin
                be        = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_word   = {2{acc_wdata[15:0]}};
                load_data = {{16{~acc_unsigned & rd_shift[15]}}, rd_shift[15:0]};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && enter_resp && acc_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response and statistics ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errs_q   <= '0;
        end else if (enter_resp) begin
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_err || acc_write) ? 32'h0 : load_data;
            if (acc_err) begin
                if (stat_errs_q != StatMax) stat_errs_q <= stat_errs_q + StatOne;
            end else if (acc_write) begin
                if (stat_stores_q != StatMax) stat_stores_q <= stat_stores_q + StatOne;
            end else begin
                if (stat_loads_q != StatMax) stat_loads_q <= stat_loads_q + StatOne;
            end
        end
    end

    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign stat_loads_o  = stat_loads_q;
    assign stat_stores_o = stat_stores_q;
    assign stat_errs_o   = stat_errs_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: one instance at LATENCY=1 (vector table, streaming)
// and one at LATENCY=4 (handshake timing, reset during an in-flight store).
module tb_dmem_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_valid, a_ready, a_write, a_uns, a_rsp_valid, a_rsp_err;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata, a_sl, a_ss, a_se;
    logic        b_rst_n, b_valid, b_ready, b_write, b_uns, b_rsp_valid, b_rsp_err;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata, b_sl, b_ss, b_se;

    dmem_port #(.DEPTH_WORDS(1024), .LATENCY(1), .STAT_WIDTH(32)) u_l1 (
        .clk_i(clk), .rst_ni(a_rst_n), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .req_write_i(a_write), .req_size_i(a_size), .req_unsigned_i(a_uns),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata), .rsp_valid_o(a_rsp_valid),
        .rsp_rdata_o(a_rdata), .rsp_err_o(a_rsp_err), .stat_loads_o(a_sl),
        .stat_stores_o(a_ss), .stat_errs_o(a_se)
    );

    dmem_port #(.DEPTH_WORDS(1024), .LATENCY(4), .STAT_WIDTH(32)) u_l4 (
        .clk_i(clk), .rst_ni(b_rst_n), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_write_i(b_write), .req_size_i(b_size), .req_unsigned_i(b_uns),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata), .rsp_valid_o(b_rsp_valid),
        .rsp_rdata_o(b_rdata), .rsp_err_o(b_rsp_err), .stat_loads_o(b_sl),
        .stat_stores_o(b_ss), .stat_errs_o(b_se)
    );

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic vec_t mk(string n, logic w, logic [1:0] sz, logic u, logic [31:0] a,
                                logic [31:0] d, logic e, logic [31:0] r);
        vec_t v;
        v.name = n; v.w = w; v.sz = sz; v.u = u; v.addr = a; v.wdata = d;
        v.err = e; v.rdata = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b_valid = v; b_write = w; b_size = sz; b_uns = u; b_addr = a; b_wdata = d;
        end else begin
            a_valid = v; a_write = w; a_size = sz; a_uns = u; a_addr = a; a_wdata = d;
        end
    endtask

    function automatic logic rdy(bit sel);
        return sel ? b_ready : a_ready;
    endfunction

    function automatic logic rvalid(bit sel);
        return sel ? b_rsp_valid : a_rsp_valid;
    endfunction

    // One request; returns error, data and cycles from accepting edge to rsp_valid.
    task automatic do_req(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic err, output logic [31:0] rd, output int lat);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, w, sz, u, a, d);
        n = 0;
        while (!rdy(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            nvec++; nfail++;
            $display("FAIL req_accept_timeout: ready=0, required 1");
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        end while (!rvalid(sel) && lat < 20);
        err = sel ? b_rsp_err : a_rsp_err;
        rd  = sel ? b_rdata : a_rdata;
    endtask

    initial begin
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          e_loads, e_stores, e_errs, pulses;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        vecs.push_back(mk("sw_100",   1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk("lw_100",   0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF));
        vecs.push_back(mk("sw0_10",   1, 2'b10, 0, 32'h010, 32'h0, 0, 32'h0));
        vecs.push_back(mk("sb_13",    1, 2'b00, 0, 32'h013, 32'h12345680, 0, 32'h0));
        vecs.push_back(mk("lw_10a",   0, 2'b10, 0, 32'h010, 32'h0, 0, 32'h80000000));
        vecs.push_back(mk("lb_13",    0, 2'b00, 0, 32'h013, 32'h0, 0, 32'hFFFFFF80));
        vecs.push_back(mk("lbu_13",   0, 2'b00, 1, 32'h013, 32'h0, 0, 32'h00000080));
        vecs.push_back(mk("sh_10",    1, 2'b01, 0, 32'h010, 32'hABCD8001, 0, 32'h0));
        vecs.push_back(mk("lh_10",    0, 2'b01, 0, 32'h010, 32'h0, 0, 32'hFFFF8001));
        vecs.push_back(mk("lhu_10",   0, 2'b01, 1, 32'h010, 32'h0, 0, 32'h00008001));
        vecs.push_back(mk("lw_10b",   0, 2'b10, 0, 32'h010, 32'h0, 0, 32'h80008001));
        vecs.push_back(mk("sh_12",    1, 2'b01, 0, 32'h012, 32'h00007F55, 0, 32'h0));
        vecs.push_back(mk("lh_12",    0, 2'b01, 0, 32'h012, 32'h0, 0, 32'h00007F55));
        vecs.push_back(mk("lb_11",    0, 2'b00, 0, 32'h011, 32'h0, 0, 32'hFFFFFF80));
        vecs.push_back(mk("lbu_10",   0, 2'b00, 1, 32'h010, 32'h0, 0, 32'h00000001));
        vecs.push_back(mk("lw_10c",   0, 2'b10, 0, 32'h010, 32'h0, 0, 32'h7F558001));
        vecs.push_back(mk("lw_mis",   0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h0));
        vecs.push_back(mk("sw_oor",   1, 2'b10, 0, 32'h1000, 32'h11111111, 1, 32'h0));
        vecs.push_back(mk("size11",   0, 2'b11, 0, 32'h100, 32'h0, 1, 32'h0));
        vecs.push_back(mk("sh_mis",   1, 2'b01, 0, 32'h101, 32'hFFFFFFFF, 1, 32'h0));
        vecs.push_back(mk("lw_100b",  0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF));
        vecs.push_back(mk("sw_last",  1, 2'b10, 0, 32'hFFC, 32'hA5A5A5A5, 0, 32'h0));
        vecs.push_back(mk("lw_last",  0, 2'b10, 0, 32'hFFC, 32'h0, 0, 32'hA5A5A5A5));
        vecs.push_back(mk("lw_oor",   0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0));

        // Reset state
        #2;
        chk("rst_ready", {31'h0, a_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, a_rsp_err}, 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_stats", a_sl | a_ss | a_se, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_ready_held", {31'h0, a_ready}, 32'h0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, a_ready}, 32'h1);

        // Vector table, LATENCY = 1
        e_loads = 0; e_stores = 0; e_errs = 0;
        foreach (vecs[i]) begin
            do_req(0, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wdata,
                   err, rd, lat);
            chk({vecs[i].name, "_err"}, {31'h0, err}, {31'h0, vecs[i].err});
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
            if (vecs[i].err) e_errs++;
            else if (vecs[i].w) e_stores++;
            else e_loads++;
        end
        @(negedge clk);
        chk("rsp_pulse_one_cycle", {31'h0, a_rsp_valid}, 32'h0);
        chk("stat_loads", a_sl, 32'(e_loads));
        chk("stat_stores", a_ss, 32'(e_stores));
        chk("stat_errs", a_se, 32'(e_errs));

        // Back-to-back: 10 sw then 10 lw, one request per cycle
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b_rsp_valid_%0d", i - 1), {31'h0, a_rsp_valid}, 32'h1);
                if (i > 10) chk($sformatf("b2b_rdata_%0d", i - 11), a_rdata, 32'(i - 11));
            end
            if (i < 20) begin
                chk($sformatf("b2b_ready_%0d", i), {31'h0, a_ready}, 32'h1);
                drive(0, 1'b1, (i < 10), 2'b10, 1'b0, 32'(4 * (i % 10)), 32'(i % 10));
            end else begin
                drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            end
            if (i < 20) @(posedge clk);
        end
        chk("b2b_stat_loads", a_sl, 32'(e_loads + 10));
        chk("b2b_stat_stores", a_ss, 32'(e_stores + 10));

        // LATENCY = 4 handshake
        @(negedge clk);
        chk("l4_ready_idle", {31'h0, b_ready}, 32'h1);
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0A0B0C0D);
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            if (c == 4 || c == 8) begin
                chk($sformatf("l4_rsp_valid_c%0d", c), {31'h0, b_rsp_valid}, 32'h1);
                chk($sformatf("l4_ready_c%0d", c), {31'h0, b_ready}, 32'h1);
                chk($sformatf("l4_err_c%0d", c), {31'h0, b_rsp_err}, 32'h0);
            end else begin
                chk($sformatf("l4_rsp_valid_c%0d", c), {31'h0, b_rsp_valid}, 32'h0);
                chk($sformatf("l4_ready_c%0d", c), {31'h0, b_ready}, 32'h0);
            end
            if (c == 4) drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
            if (c == 8) chk("l4_rdata", b_rdata, 32'h0A0B0C0D);
        end
        @(negedge clk);
        chk("l4_rsp_done", {31'h0, b_rsp_valid}, 32'h0);

        // Reset during an in-flight store
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, err, rd, lat);
        chk("l4_preset_lat", 32'(lat), 32'd4);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000055);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        pulses = b_rsp_valid ? 1 : 0;
        @(negedge clk);
        b_rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'h0, b_ready}, 32'h0);
        chk("midrst_stats", b_sl | b_ss | b_se, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_rsp_valid) pulses++;
        end
        b_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (b_rsp_valid) pulses++;
        end
        chk("midrst_no_rsp", 32'(pulses), 32'd0);
        chk("midrst_stat_loads", b_sl, 32'h0);
        chk("midrst_stat_stores", b_ss, 32'h0);
        chk("midrst_stat_errs", b_se, 32'h0);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, err, rd, lat);
        chk("midrst_lw_rdata", rd, 32'h12345678);
        chk("midrst_lw_lat", 32'(lat), 32'd4);
        chk("midrst_stat_loads_after", b_sl, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Synthesizable, parametrised data-memory port for the pipelined RISC-V core; replaces the ad-hoc zero-latency word memory used so far.
- Adds a valid/ready request channel, configurable access latency, byte/half/word stores with lane masking, and sign/zero-extended loads.
- Flags misaligned and out-of-range accesses, and keeps saturating access statistics.
- Sits between the core's MEM stage and backing storage; the core stalls while req_ready is low.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- LATENCY, 1, cycles from the request-acceptance edge to rsp_valid; legal range 1..8.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at the rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as misaligned (error).
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (bits [7:0] for sb).
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid only with rsp_valid; 1 = misaligned, size 11, or addr >= DEPTH_WORDS*4.
- stat_loads  out  STAT_WIDTH  completed error-free loads, saturating.
- stat_stores  out  STAT_WIDTH  completed error-free stores, saturating.
- stat_errs  out  STAT_WIDTH  error responses, saturating.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All stat counters = 0; req_ready = 0 while reset is asserted.
  - Memory array is not cleared.
- FSM states:
  - IDLE: req_ready = 1. On accept, capture all req_* fields and load the wait counter with LATENCY-1. Go to RESP if LATENCY = 1, else to WAIT.
  - WAIT: req_ready = 0. Decrement the counter; at 0, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle; req_ready = 1. A request accepted in this cycle goes to RESP (LATENCY = 1) or WAIT; otherwise go to IDLE.
  - Result with LATENCY = 1: one request accepted per cycle, and rsp_valid for each request appears exactly LATENCY cycles after its accepting edge.
- Access timing:
  - Array write and read sampling both occur on the edge that enters RESP.
  - rsp_rdata and rsp_err are registered on that same edge.
  - A load accepted during a store's RESP cycle observes the stored data.
- Alignment check:
  - Half requires addr[0] = 0; word requires addr[1:0] = 00.
  - Word index = addr[log2(DEPTH_WORDS*4)-1:2].
  - Any address >= DEPTH_WORDS*4 is an error; there is no wrap-around.
- Error response: rsp_err = 1, rsp_rdata = 0, array unchanged, stat_errs increments.
- Store byte lanes, selected by addr[1:0]:
  - sb writes only lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all four lanes.
  - Unselected lanes are preserved.
- Load extraction:
  - Select the lane(s) as for stores, right-align them.
  - Sign-extend from bit 7 or bit 15 unless req_unsigned = 1; word loads are returned unmodified.
- Statistics: each counter increments on the RESP edge of its access class and holds at 2^STAT_WIDTH-1.
- Reset mid-operation: an in-flight request is dropped, no array write occurs, and no response is produced.
- X-safety: req_* fields are ignored while req_valid = 0.

Test Plan:
- Basic store/load (LATENCY = 1):
  - sw 0xDEADBEEF @0x100, then lw @0x100 → rsp_rdata = 0xDEADBEEF, one cycle after accept, rsp_err = 0.
  - stat_stores = 1, stat_loads = 1.
- Byte lanes and extension:
  - sw 0 @0x10, then sb 0x80 @0x13 → word reads 0x80000000.
  - lb @0x13 → 0xFFFFFF80; lbu @0x13 → 0x00000080.
  - sh 0x8001 @0x10, then lh @0x10 → 0xFFFF8001; lhu @0x10 → 0x00008001.
- Latency and handshake (LATENCY = 4):
  - Accept at edge k → req_ready = 0 for cycles k+1..k+3, rsp_valid high only in cycle k+4 with req_ready = 1.
  - A request issued in cycle k+4 is accepted → its response arrives at k+8.
- Errors:
  - lw @0x102 → rsp_err = 1, rdata = 0.
  - sw @DEPTH_WORDS*4 → rsp_err = 1, array unchanged.
  - req_size = 11 → rsp_err = 1.
  - stat_errs = 3, stat_loads and stat_stores unchanged.
- Back-to-back and read-after-write (LATENCY = 1):
  - 10 consecutive sw i @4*i, then 10 consecutive lw → every rsp_rdata = i.
  - req_ready stays high throughout.
- Reset mid-operation (LATENCY = 4):
  - Assert reset two cycles after accepting sw 0x55 @0x20 → no rsp_valid.
  - After reset release, lw @0x20 returns the pre-existing value; all stat counters = 0.
